tick_monitor: RTL

//  Receive-side checker for the periodic one-cycle `done` tick that the timer block emits.
//  - Measures the interval between successive rising edges on `tick`.
//  - Classifies each interval as early, good or late against PERIOD +/- TOL.
//  - Reports lock status, pulses on errors and keeps a saturating error count.
//  - Sits beside the timer in the debug datapath to prove tick cadence on hardware.

---
 rtl/tick_monitor_if.sv | 37 +++
 rtl/tick_monitor.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/tick_monitor_if.sv
// Bus bundle for tick_monitor: control inputs plus status/measurement outputs.
// The min/max statistics signals exist only when TICK_MON_STATS_EN is defined.
interface tick_monitor_if #(
    parameter int CNT_W = 21,
    parameter int ERR_W = 8
);
    logic             enable;
    logic             tick;
    logic             clear_err;
    logic             locked;
    logic             err_early;
    logic             err_late;
    logic [ERR_W-1:0] err_count;
    logic [CNT_W-1:0] last_period;
`ifdef TICK_MON_STATS_EN
    logic [CNT_W-1:0] min_period;
    logic [CNT_W-1:0] max_period;

    modport master (
        output enable, tick, clear_err,
        input  locked, err_early, err_late, err_count, last_period, min_period, max_period
    );
    modport slave (
        input  enable, tick, clear_err,
        output locked, err_early, err_late, err_count, last_period, min_period, max_period
    );
`else
    modport master (
        output enable, tick, clear_err,
        input  locked, err_early, err_late, err_count, last_period
    );
    modport slave (
        input  enable, tick, clear_err,
        output locked, err_early, err_late, err_count, last_period
    );
`endif
endinterface

// File: rtl/tick_monitor.sv
// Tick cadence checker: measures edge-to-edge intervals of `tick`, classifies them against
// PERIOD +/- TOL and tracks lock/errors. TICK_MON_STATS_EN adds min/max interval outputs.
module tick_monitor #(
    parameter int PERIOD = 2000000,
    parameter int TOL    = 16,
    parameter int CNT_W  = 21,
    parameter int ERR_W  = 8
) (
    input  logic          clk,
    input  logic          reset,
    tick_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACQ, LOCK, LOST} state_t;

    localparam logic [CNT_W-1:0] LO = CNT_W'(PERIOD - TOL);
    localparam logic [CNT_W-1:0] HI = CNT_W'(PERIOD + TOL);

    state_t           state, state_nxt;
    logic             tick_d;
    logic             tick_edge;
    logic [CNT_W-1:0] count, count_nxt;
    logic [CNT_W-1:0] measured;
    logic             meas_vld;
    logic             locked_q, locked_nxt;
    logic             early_q, early_nxt;
    logic             late_q, late_nxt;
    logic             err_hit;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_nxt;
    logic [CNT_W-1:0] last_q, last_nxt;
`ifdef TICK_MON_STATS_EN
    logic [CNT_W-1:0] min_q, min_nxt;
    logic [CNT_W-1:0] max_q, max_nxt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tick_d    <= 1'b0;
            count     <= '0;
            locked_q  <= 1'b0;
            early_q   <= 1'b0;
            late_q    <= 1'b0;
            err_cnt_q <= '0;
            last_q    <= '0;
`ifdef TICK_MON_STATS_EN
            min_q     <= '1;
            max_q     <= '0;
`endif
        end else begin
            state     <= state_nxt;
            tick_d    <= bus.tick;
            count     <= count_nxt;
            locked_q  <= locked_nxt;
            early_q   <= early_nxt;
            late_q    <= late_nxt;
            err_cnt_q <= err_cnt_nxt;
            last_q    <= last_nxt;
`ifdef TICK_MON_STATS_EN
            min_q     <= min_nxt;
            max_q     <= max_nxt;
`endif
        end
    end

    always_comb begin
        tick_edge  = bus.tick & ~tick_d;
        measured   = count + 1'b1;
        state_nxt  = state;
        count_nxt  = count;
        locked_nxt = locked_q;
        early_nxt  = 1'b0;
        late_nxt   = 1'b0;
        last_nxt   = last_q;
        meas_vld   = 1'b0;

        if (!bus.enable) begin
            state_nxt  = IDLE;
            count_nxt  = '0;
            locked_nxt = 1'b0;
        end else begin
            case (state)
                IDLE, LOST: begin
                    // First edge only establishes the reference point.
                    if (tick_edge) begin
                        state_nxt = ACQ;
                        count_nxt = '0;
                    end
                end
                ACQ, LOCK: begin
                    if (tick_edge) begin
                        count_nxt = '0;
                        last_nxt  = measured;
                        meas_vld  = 1'b1;
                        if (measured >= LO) begin
                            state_nxt  = LOCK;
                            locked_nxt = 1'b1;
                        end else begin
                            state_nxt  = ACQ;
                            locked_nxt = 1'b0;
                            early_nxt  = 1'b1;
                        end
                    end else if (count == HI) begin
                        // Counter parks here in LOST, so the late pulse fires once.
                        state_nxt  = LOST;
                        locked_nxt = 1'b0;
                        late_nxt   = 1'b1;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    count_nxt  = '0;
                    locked_nxt = 1'b0;
                end
            endcase
        end

        err_hit     = early_nxt | late_nxt;
        err_cnt_nxt = err_cnt_q;
        if (bus.clear_err)
            err_cnt_nxt = {{(ERR_W-1){1'b0}}, err_hit};
        else if (err_hit && (err_cnt_q != {ERR_W{1'b1}}))
            err_cnt_nxt = err_cnt_q + 1'b1;

`ifdef TICK_MON_STATS_EN
        min_nxt = min_q;
        max_nxt = max_q;
        if (bus.clear_err) begin
            min_nxt = '1;
            max_nxt = '0;
        end
        if (meas_vld) begin
            if (measured < min_nxt) min_nxt = measured;
            if (measured > max_nxt) max_nxt = measured;
        end
`endif
    end

    assign bus.locked      = locked_q;
    assign bus.err_early   = early_q;
    assign bus.err_late    = late_q;
    assign bus.err_count   = err_cnt_q;
    assign bus.last_period = last_q;
`ifdef TICK_MON_STATS_EN
    assign bus.min_period  = min_q;
    assign bus.max_period  = max_q;
`endif
endmodule
